t04_data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store request interface (mem_read, mem_write, addr_to_mem, data_to_mem, select).

---
 rtl/t04_mem_pkg.sv | 25 ++
 rtl/t04_byte_lane_ram.sv | 43 ++++
 rtl/t04_data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_t04_data_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t04_mem_pkg.sv
// Shared types and constants for the t04 data-memory responder.
package t04_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Expands a 4-bit lane select into a 32-bit mask, one byte per lane.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [3:0] sel);
    logic [WORD_W-1:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/t04_byte_lane_ram.sv
// Word-addressed store with per-byte write enables, async clear and a combinational read port.
module t04_byte_lane_ram
  import t04_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] mem_d [DEPTH_WORDS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/t04_data_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES latency, one-cycle ack.
// Define T04_ADDR_CHECK_EN to flag out-of-range / misaligned requests with err.
module t04_data_mem_responder
  import t04_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr_to_mem,
  input  logic [WORD_W-1:0] data_to_mem,
  input  logic [3:0]        select,
  output logic [WORD_W-1:0] data_from_mem,
  output logic              busy,
  output logic              ack,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              bad_q, bad_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              req;
  logic [32:0]       diff;
  logic [31:0]       addr_off;
  logic [IDX_W-1:0]  in_idx;
  logic              in_bad;
  logic              unused_addr_bits;

  logic              op_wr, op_bad, entering_done, ram_we;
  logic [IDX_W-1:0]  op_idx;
  logic [WORD_W-1:0] op_wdata, ram_rdata;
  logic [3:0]        op_sel;

  assign req      = mem_read | mem_write;
  assign diff     = {1'b0, addr_to_mem} - {1'b0, BASE_ADDR};
  assign addr_off = diff[31:0];
  assign in_idx   = addr_off[IDX_W+1:2];
  assign unused_addr_bits = ^{diff[32], addr_off[31:IDX_W+2], addr_off[1:0]};

`ifdef T04_ADDR_CHECK_EN
  assign in_bad = diff[32]
               || (|addr_off[31:IDX_W+2])
               || ((select == SEL_HALF) && addr_to_mem[0])
               || ((select == SEL_WORD) && (addr_to_mem[1:0] != 2'b00));
`else
  assign in_bad = 1'b0;
`endif

  // With zero wait states the commit edge is also the capture edge, so IDLE uses live inputs.
  always_comb begin
    if (state_q == IDLE) begin
      op_wr    = mem_write;
      op_bad   = in_bad;
      op_idx   = in_idx;
      op_wdata = data_to_mem;
      op_sel   = select;
    end else begin
      op_wr    = wr_q;
      op_bad   = bad_q;
      op_idx   = idx_q;
      op_wdata = wdata_q;
      op_sel   = sel_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = mem_write;
          bad_d   = in_bad;
          idx_d   = in_idx;
          wdata_d = data_to_mem;
          sel_d   = select;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    entering_done = (state_d == DONE) && (state_q != DONE);
    ram_we        = entering_done && op_wr && !op_bad;
    if (entering_done && !op_wr) begin
      rdata_d = op_bad ? '0 : (ram_rdata & lane_mask(op_sel));
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  t04_byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (nRst),
    .we    (ram_we),
    .be    (op_sel),
    .idx   (op_idx),
    .wdata (op_wdata),
    .rdata (ram_rdata)
  );

  assign data_from_mem = rdata_q;
  assign busy          = (state_q != IDLE);
  assign ack           = (state_q == DONE);
  assign err           = (state_q == DONE) && bad_q;

endmodule

// File: tb/tb_t04_data_mem_responder.sv
// Scoreboard bench for t04_data_mem_responder: directed cases plus randomized traffic
// against a byte-array reference model; honours T04_ADDR_CHECK_EN like the design.
module tb_t04_data_mem_responder;

  localparam int          DEPTH = 256;
  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr_to_mem = '0;
  logic [31:0] data_to_mem = '0;
  logic [3:0]  select = '0;
  logic [31:0] data_from_mem;
  logic        busy, ack, err;

  t04_data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .addr_to_mem   (addr_to_mem),
    .data_to_mem   (data_to_mem),
    .select        (select),
    .data_from_mem (data_from_mem),
    .busy          (busy),
    .ack           (ack),
    .err           (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  model_mem [DEPTH][4];
  logic [31:0] model_dout = '0;
  int          busy_lo = -10;
  int          busy_hi = -20;
  bit          mon_en = 1'b0;
  bit          ack_seen = 1'b0;

  // Reference model: byte array indexed by word, with address decoding in plain arithmetic.
  function automatic int word_of(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % 32'(DEPTH));
  endfunction

  function automatic bit is_bad(logic [31:0] a, logic [3:0] s);
`ifdef T04_ADDR_CHECK_EN
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || (off / 4) >= DEPTH) return 1'b1;
    if (s == 4'b0011 && (a % 2) != 0) return 1'b1;
    if (s == 4'b1111 && (a % 4) != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < 4; b++)
        model_mem[w][b] = 8'h00;
    model_dout = '0;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and tracks the expected busy window.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      checkOutput("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (ack) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_ack", 32'(ack), 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("data_from_mem", data_from_mem, e.data);
          checkOutput("err", 32'(err), 32'(e.err));
          ack_seen = 1'b1;
        end
      end else begin
        checkOutput("err_without_ack", 32'(err), 32'd0);
      end
    end
  end

  task automatic applyStimulus(bit rd, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    exp_t e;
    int   w;
    bit   bad;
    @(negedge clk);
    mem_read    = rd;
    mem_write   = wr;
    addr_to_mem = a;
    data_to_mem = d;
    select      = s;
    w   = word_of(a);
    bad = is_bad(a, s);
    if (wr) begin
      if (!bad)
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[w][b] = d[8*b +: 8];
    end else begin
      model_dout = '0;
      if (!bad)
        for (int b = 0; b < 4; b++)
          if (s[b]) model_dout[8*b +: 8] = model_mem[w][b];
    end
    @(posedge clk);
    #1;
    e.cyc    = cyc + WS;
    e.data   = model_dout;
    e.err    = bad;
    busy_lo  = cyc;
    busy_hi  = cyc + WS;
    ack_seen = 1'b0;
    sb_q.push_back(e);
    // Scramble inputs while busy; the captured request must be used and nothing re-accepted.
    @(negedge clk);
    mem_read    = 1'($urandom);
    mem_write   = 1'($urandom);
    addr_to_mem = $urandom;
    data_to_mem = $urandom;
    select      = 4'($urandom);
    for (int i = 0; i < WS + 8; i++) begin
      if (ack_seen) break;
      @(negedge clk);
      #1;
    end
    if (!ack_seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ack_timeout: got no ack expected ack by cycle %0d", e.cyc);
      sb_q.delete();
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic reset_mid_write(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    mem_write   = 1'b1;
    addr_to_mem = a;
    data_to_mem = d;
    select      = 4'hF;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    mon_en    = 1'b0;
    nRst      = 1'b0;
    #1;
    sb_q.delete();
    busy_lo = -10;
    busy_hi = -20;
    model_clear();
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_ack", 32'(ack), 32'd0);
    checkOutput("rst_mid_data", data_from_mem, 32'd0);
    @(negedge clk);
    nRst   = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    bit          rd, wr;

    model_clear();
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_data", data_from_mem, 32'd0);
    nRst   = 1'b1;
    mon_en = 1'b1;

    $display("[TB] directed: reset read, word/byte/half accesses");
    applyStimulus(1, 0, BASE, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1, 0, BASE + 32'h10, 32'h0, 4'hF);
    applyStimulus(0, 1, BASE + 32'h10, 32'h0000_0055, 4'h1);
    applyStimulus(1, 0, BASE + 32'h10, 32'h0, 4'hF);
    applyStimulus(0, 1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
    applyStimulus(0, 1, BASE + 32'h20, 32'h0000_1234, 4'h3);
    applyStimulus(1, 0, BASE + 32'h20, 32'h0, 4'h3);
    applyStimulus(1, 0, BASE + 32'h20, 32'h0, 4'hF);
    applyStimulus(0, 1, BASE + 32'h24, 32'h7777_7777, 4'h0);
    applyStimulus(1, 0, BASE + 32'h24, 32'h0, 4'hF);

    $display("[TB] directed: simultaneous read/write and mid-write reset");
    applyStimulus(1, 1, BASE + 32'h30, 32'hA5A5_A5A5, 4'hF);
    applyStimulus(1, 0, BASE + 32'h30, 32'h0, 4'hF);
    applyStimulus(0, 1, BASE + 32'h40, 32'h1357_9BDF, 4'hF);
    reset_mid_write(BASE + 32'h40, 32'hFEED_FACE);
    applyStimulus(1, 0, BASE + 32'h40, 32'h0, 4'hF);
    applyStimulus(1, 0, BASE + 32'h10, 32'h0, 4'hF);

    $display("[TB] directed: misaligned and out-of-range accesses");
    applyStimulus(0, 1, BASE + 32'h10, 32'h0BAD_F00D, 4'hF);
    applyStimulus(1, 0, BASE + 32'h13, 32'h0, 4'hF);
    applyStimulus(0, 1, BASE + 32'(4 * DEPTH), 32'h1122_3344, 4'hF);
    applyStimulus(1, 0, BASE, 32'h0, 4'hF);
    applyStimulus(1, 0, BASE + 32'h21, 32'h0, 4'h3);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 4))
        0:       s = 4'b0001;
        1:       s = 4'b0011;
        2:       s = 4'b1111;
        default: s = 4'($urandom);
      endcase
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      applyStimulus(rd, wr, a, $urandom, s);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
